// File: rtl/lb_master_arb.sv
// Round-robin arbiter sharing one localbus among MST_NUM masters.
// Per-master write/read slots, one transaction in flight, ack timeout guard.
module lb_master_arb #(
  parameter int                        LB_DATA_WDTH = 32,
  parameter int                        LB_ADDR_WDTH = 32,
  parameter int                        MST_NUM      = 3,
  parameter int                        TO_CYC       = 255,
  parameter logic [LB_DATA_WDTH-1:0]   TO_RDATA     = 32'hDEAD_BEEF
) (
  input  logic                             lb_clk,
  input  logic                             lb_rst_n,
  input  logic [MST_NUM-1:0]               m_wreq,
  input  logic [LB_ADDR_WDTH*MST_NUM-1:0]  m_waddr,
  input  logic [LB_DATA_WDTH*MST_NUM-1:0]  m_wdata,
  output logic [MST_NUM-1:0]               m_wack,
  input  logic [MST_NUM-1:0]               m_rreq,
  input  logic [LB_ADDR_WDTH*MST_NUM-1:0]  m_raddr,
  output logic [LB_DATA_WDTH-1:0]          m_rdata,
  output logic [MST_NUM-1:0]               m_rack,
  output logic                             lb_wreq,
  output logic [LB_ADDR_WDTH-1:0]          lb_waddr,
  output logic [LB_DATA_WDTH-1:0]          lb_wdata,
  input  logic                             lb_wack,
  output logic                             lb_rreq,
  output logic [LB_ADDR_WDTH-1:0]          lb_raddr,
  input  logic [LB_DATA_WDTH-1:0]          lb_rdata,
  input  logic                             lb_rack,
  output logic                             to_err,
  output logic [15:0]                      to_cnt
);

  localparam int PW = $clog2(MST_NUM);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]              state;
  logic [MST_NUM-1:0]      wpend, rpend, pend;
  logic [LB_ADDR_WDTH-1:0] waddr_q [MST_NUM];
  logic [LB_DATA_WDTH-1:0] wdata_q [MST_NUM];
  logic [LB_ADDR_WDTH-1:0] raddr_q [MST_NUM];
  logic [PW-1:0]           ptr, gnt, gnt_nxt;
  logic                    cur_wr;
  logic                    ack_ok;
  logic [15:0]             to_tmr;

  assign pend   = wpend | rpend;
  assign ack_ok = cur_wr ? lb_wack : lb_rack;

  // Round-robin search starting one past the last granted master.
  always_comb begin
    int  idx;
    logic found;
    // NOTE: every variable gets a default first so no path infers a latch.
    gnt_nxt = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= MST_NUM; k++) begin
      idx = int'(ptr) + k;
      if (idx >= MST_NUM) idx = idx - MST_NUM;
      if (!found && pend[idx]) begin
        found   = 1'b1;
        gnt_nxt = PW'(idx);
      end
    end
  end

  // Slot flags: the served slot clears in ISSUE; a pulse into a set slot is dropped.
  always_ff @(posedge lb_clk or negedge lb_rst_n) begin
    if (!lb_rst_n) begin
      wpend <= '0;
      rpend <= '0;
    end else begin
      for (int i = 0; i < MST_NUM; i++) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (state == ISSUE && gnt == PW'(i) && cur_wr) wpend[i] <= 1'b0;
        else if (m_wreq[i])                            wpend[i] <= 1'b1;
        if (state == ISSUE && gnt == PW'(i) && !cur_wr) rpend[i] <= 1'b0;
        else if (m_rreq[i])                             rpend[i] <= 1'b1;
      end
    end
  end

  // NOTE: slot payload storage needs no reset; the pending flags qualify it.
  always_ff @(posedge lb_clk) begin
    for (int i = 0; i < MST_NUM; i++) begin
      if (m_wreq[i] && !wpend[i]) begin
        waddr_q[i] <= m_waddr[LB_ADDR_WDTH*i +: LB_ADDR_WDTH];
        wdata_q[i] <= m_wdata[LB_DATA_WDTH*i +: LB_DATA_WDTH];
      end
      if (m_rreq[i] && !rpend[i]) raddr_q[i] <= m_raddr[LB_ADDR_WDTH*i +: LB_ADDR_WDTH];
    end
  end

  always_ff @(posedge lb_clk or negedge lb_rst_n) begin
    if (!lb_rst_n) begin
      state    <= IDLE;
      ptr      <= PW'(MST_NUM - 1);
      gnt      <= '0;
      cur_wr   <= 1'b0;
      to_tmr   <= '0;
      m_wack   <= '0;
      m_rack   <= '0;
      m_rdata  <= '0;
      lb_wreq  <= 1'b0;
      lb_waddr <= '0;
      lb_wdata <= '0;
      lb_rreq  <= 1'b0;
      lb_raddr <= '0;
      to_err   <= 1'b0;
      to_cnt   <= '0;
    end else begin
      m_wack  <= '0;
      m_rack  <= '0;
      to_err  <= 1'b0;
      lb_wreq <= 1'b0;
      lb_rreq <= 1'b0;
      case (state)
        IDLE: begin
          if (|pend) begin
            gnt    <= gnt_nxt;
            ptr    <= gnt_nxt;
            cur_wr <= wpend[gnt_nxt];
            // A master with both slots pending gets its write served first.
            if (wpend[gnt_nxt]) begin
              lb_wreq  <= 1'b1;
              lb_waddr <= waddr_q[gnt_nxt];
              lb_wdata <= wdata_q[gnt_nxt];
            end else begin
              lb_rreq  <= 1'b1;
              lb_raddr <= raddr_q[gnt_nxt];
            end
            state <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (ack_ok) begin
            if (cur_wr) m_wack[gnt] <= 1'b1;
            else begin
              m_rack[gnt] <= 1'b1;
              m_rdata     <= lb_rdata;
            end
            state <= RESP;
          end else if (state == ISSUE) begin
            to_tmr <= 16'd1;
            state  <= WAIT;
          end else if (to_tmr == 16'(TO_CYC)) begin
            if (cur_wr) m_wack[gnt] <= 1'b1;
            else begin
              m_rack[gnt] <= 1'b1;
              m_rdata     <= TO_RDATA;
            end
            to_err <= 1'b1;
            if (to_cnt != 16'hFFFF) to_cnt <= to_cnt + 16'd1;
            state <= RESP;
          end else begin
            to_tmr <= to_tmr + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_master_arb.sv
// Bench for lb_master_arb: table of single transactions plus hand sequences,
// with a responding slave and queue-based scoreboard of strobes and master acks.
module tb_lb_master_arb;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MN = 3;
  localparam int TO = 8;
  localparam logic [DW-1:0] TO_RD = 32'hDEAD_BEEF;

  logic             lb_clk = 1'b0;
  logic             lb_rst_n = 1'b0;
  logic [MN-1:0]    m_wreq = '0, m_rreq = '0;
  logic [AW*MN-1:0] m_waddr = '0, m_raddr = '0;
  logic [DW*MN-1:0] m_wdata = '0;
  logic [MN-1:0]    m_wack, m_rack;
  logic [DW-1:0]    m_rdata;
  logic             lb_wreq, lb_rreq, lb_wack, lb_rack, to_err;
  logic [AW-1:0]    lb_waddr, lb_raddr;
  logic [DW-1:0]    lb_wdata, lb_rdata;
  logic [15:0]      to_cnt;

  always #5 lb_clk = ~lb_clk;

  lb_master_arb #(
    .LB_DATA_WDTH(DW), .LB_ADDR_WDTH(AW), .MST_NUM(MN), .TO_CYC(TO), .TO_RDATA(TO_RD)
  ) dut (
    .lb_clk(lb_clk), .lb_rst_n(lb_rst_n),
    .m_wreq(m_wreq), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wack(m_wack),
    .m_rreq(m_rreq), .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rack(m_rack),
    .lb_wreq(lb_wreq), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wack(lb_wack),
    .lb_rreq(lb_rreq), .lb_raddr(lb_raddr), .lb_rdata(lb_rdata), .lb_rack(lb_rack),
    .to_err(to_err), .to_cnt(to_cnt)
  );

  typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; } strobe_t;
  typedef struct { int mst; bit wr; logic [DW-1:0] rdata; bit to; } ack_t;
  typedef struct {
    int mst; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    int delay; bit wrong; logic [DW-1:0] srdata; logic [DW-1:0] exp_rdata;
  } vec_t;

  strobe_t exp_strobes[$];
  ack_t    exp_acks[$];

  int checks = 0, errors = 0;
  int cyc = 0, strobe_cyc = 0, sack_cyc = 0, mack_cyc = -100;
  int exp_to = 0, n_strobes = 0;
  bit outstanding = 0;
  int slave_delay = -1;
  bit slave_wrong = 0;
  logic [DW-1:0] slave_rdata = '0;

  always @(posedge lb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave: acks each strobe after slave_delay cycles, optionally preceded by a wrong-type ack.
  initial begin
    bit s_wr;
    int s_left;
    lb_wack = 1'b0; lb_rack = 1'b0; lb_rdata = '0;
    forever begin
      @(negedge lb_clk);
      if (lb_rst_n && (lb_wreq || lb_rreq) && slave_delay >= 0) begin
        s_wr   = lb_wreq;
        s_left = slave_delay;
        if (slave_wrong) begin
          @(negedge lb_clk);
          if (s_wr) lb_rack = 1'b1; else lb_wack = 1'b1;
          @(negedge lb_clk);
          lb_wack = 1'b0; lb_rack = 1'b0;
          s_left = slave_delay - 2;
        end
        repeat (s_left) @(negedge lb_clk);
        if (s_wr) lb_wack = 1'b1; else lb_rack = 1'b1;
        lb_rdata = slave_rdata;
        sack_cyc = cyc;
        @(negedge lb_clk);
        lb_wack = 1'b0; lb_rack = 1'b0; lb_rdata = '0;
      end
    end
  end

  // Monitor: pops scoreboard entries as strobes and master acks appear.
  initial begin
    strobe_t ms;
    ack_t    ma;
    logic [MN-1:0] mask;
    forever begin
      @(negedge lb_clk);
      if (lb_rst_n) begin
        if (lb_wreq || lb_rreq) begin
          n_strobes++;
          check("one_outstanding", outstanding, 0);
          check("single_strobe", lb_wreq & lb_rreq, 0);
          check("strobe_gap", (cyc - mack_cyc) >= 2, 1);
          check("strobe_expected", exp_strobes.size() != 0, 1);
          if (exp_strobes.size() != 0) begin
            ms = exp_strobes.pop_front();
            check("strobe_type", lb_wreq, ms.wr);
            if (ms.wr) begin
              check("lb_waddr", lb_waddr, ms.addr);
              check("lb_wdata", lb_wdata, ms.data);
            end else begin
              check("lb_raddr", lb_raddr, ms.addr);
            end
          end
          strobe_cyc  = cyc;
          outstanding = 1'b1;
        end
        if ((|m_wack) || (|m_rack)) begin
          check("ack_expected", exp_acks.size() != 0, 1);
          if (exp_acks.size() != 0) begin
            ma   = exp_acks.pop_front();
            mask = MN'(1) << ma.mst;
            check("m_wack", m_wack, ma.wr ? mask : '0);
            check("m_rack", m_rack, ma.wr ? '0 : mask);
            if (!ma.wr) check("m_rdata", m_rdata, ma.rdata);
            check("to_err", to_err, ma.to);
            if (ma.to) begin
              exp_to++;
              check("to_cnt", to_cnt, exp_to);
            end else begin
              check("ack_latency", cyc - sack_cyc, 1);
            end
          end
          mack_cyc    = cyc;
          outstanding = 1'b0;
        end else if (to_err) begin
          check("to_err_without_ack", to_err, 0);
        end
      end
    end
  end

  task automatic set_w(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_waddr[AW*m +: AW] = a;
    m_wdata[DW*m +: DW] = d;
  endtask

  task automatic set_r(input int m, input logic [AW-1:0] a);
    m_raddr[AW*m +: AW] = a;
  endtask

  task automatic push_s(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    strobe_t s;
    s.wr = wr; s.addr = a; s.data = d;
    exp_strobes.push_back(s);
  endtask

  task automatic push_a(input int m, input bit wr, input logic [DW-1:0] rd, input bit to);
    ack_t a;
    a.mst = m; a.wr = wr; a.rdata = rd; a.to = to;
    exp_acks.push_back(a);
  endtask

  task automatic pulse(input logic [MN-1:0] wm, input logic [MN-1:0] rm);
    m_wreq = wm; m_rreq = rm;
    @(negedge lb_clk);
    m_wreq = '0; m_rreq = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (exp_acks.size() != 0 && n < budget) begin
      @(negedge lb_clk);
      n++;
    end
    check({"done_", name}, exp_acks.size(), 0);
    if (exp_acks.size() != 0) begin
      exp_acks.delete();
      exp_strobes.delete();
      outstanding = 1'b0;
    end
    repeat (2) @(negedge lb_clk);
  endtask

  initial begin
    vec_t vecs [6];
    logic [DW-1:0] last_rdata;
    logic [MN-1:0] mk;
    int req_cyc, n, strobes_before;

    vecs[0] = '{1, 1'b1, 32'h0000_0010, 32'h1234_5678, 3, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{0, 1'b0, 32'h0000_0020, 32'h0, 2, 1'b0, 32'hA5A5_0001, 32'hA5A5_0001};
    vecs[2] = '{2, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 0, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{0, 1'b0, 32'h0000_0044, 32'h0, 5, 1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D};
    vecs[4] = '{1, 1'b1, 32'h0000_0048, 32'h55AA_55AA, 4, 1'b1, 32'h0, 32'h0};
    vecs[5] = '{2, 1'b0, 32'h0000_004C, 32'h0, TO, 1'b0, 32'h1357_2468, 32'h1357_2468};

    // Reset state
    repeat (3) @(negedge lb_clk);
    check("reset_outputs_zero",
          |{m_wack, m_rack, m_rdata, lb_wreq, lb_waddr, lb_wdata, lb_rreq, lb_raddr, to_err, to_cnt}, 0);
    lb_rst_n = 1'b1;
    repeat (3) @(negedge lb_clk);
    check("idle_after_reset", lb_wreq | lb_rreq, 0);

    // Contention right after reset: pointer starts at MN-1, so M0, M1, M2
    slave_delay = 1; slave_wrong = 0; slave_rdata = 32'h1111_0000;
    set_r(0, 32'h100); set_r(1, 32'h104); set_r(2, 32'h108);
    push_s(0, 32'h100, '0); push_s(0, 32'h104, '0); push_s(0, 32'h108, '0);
    push_a(0, 0, 32'h1111_0000, 0); push_a(1, 0, 32'h1111_0000, 0); push_a(2, 0, 32'h1111_0000, 0);
    pulse('0, 3'b111);
    wait_done("contention_3", 60);
    set_r(0, 32'h200); set_r(2, 32'h208);
    push_s(0, 32'h200, '0); push_s(0, 32'h208, '0);
    push_a(0, 0, 32'h1111_0000, 0); push_a(2, 0, 32'h1111_0000, 0);
    pulse('0, 3'b101);
    wait_done("contention_2", 60);
    last_rdata = 32'h1111_0000;

    // Single transactions from the table
    for (int i = 0; i < 6; i++) begin
      slave_delay = vecs[i].delay;
      slave_wrong = vecs[i].wrong;
      slave_rdata = vecs[i].srdata;
      mk = MN'(1) << vecs[i].mst;
      if (vecs[i].wr) begin
        set_w(vecs[i].mst, vecs[i].addr, vecs[i].wdata);
        push_s(1, vecs[i].addr, vecs[i].wdata);
        push_a(vecs[i].mst, 1, '0, 0);
      end else begin
        set_r(vecs[i].mst, vecs[i].addr);
        push_s(0, vecs[i].addr, '0);
        push_a(vecs[i].mst, 0, vecs[i].exp_rdata, 0);
        last_rdata = vecs[i].exp_rdata;
      end
      req_cyc = cyc;
      pulse(vecs[i].wr ? mk : '0, vecs[i].wr ? '0 : mk);
      wait_done("vec", 40);
      check("vec_strobe_latency", strobe_cyc - req_cyc, 2);
      check("vec_rdata_hold", m_rdata, last_rdata);
    end

    // Same-master write+read, then a duplicate read while the read is pending
    slave_delay = 2; slave_wrong = 0; slave_rdata = 32'h0A0B_0C0D;
    set_w(1, 32'h400, 32'hFACE_B00C); set_r(1, 32'h404);
    push_s(1, 32'h400, 32'hFACE_B00C); push_s(0, 32'h404, '0);
    push_a(1, 1, '0, 0); push_a(1, 0, 32'h0A0B_0C0D, 0);
    pulse(3'b010, 3'b010);
    @(negedge lb_clk);
    set_r(1, 32'h4FF);
    pulse('0, 3'b010);
    wait_done("mixed", 40);
    repeat (5) @(negedge lb_clk);

    // Timeout with the slave answering two cycles after the timeout ack
    slave_delay = TO + 3; slave_rdata = 32'h7777_7777;
    set_r(2, 32'h200C);
    push_s(0, 32'h200C, '0);
    push_a(2, 0, TO_RD, 1);
    pulse('0, 3'b100);
    wait_done("timeout", 40);
    check("to_cnt_one", to_cnt, 1);
    repeat (6) @(negedge lb_clk);
    check("rdata_after_late_ack", m_rdata, TO_RD);
    check("to_cnt_after_late_ack", to_cnt, 1);

    // Reset while a read waits and other slots are pending
    slave_delay = -1;
    set_r(0, 32'h300);
    push_s(0, 32'h300, '0);
    pulse('0, 3'b001);
    n = 0;
    while (!outstanding && n < 10) begin
      @(negedge lb_clk);
      n++;
    end
    check("rst_test_strobe_seen", outstanding, 1);
    set_w(1, 32'h310, 32'h3131_3131); set_r(2, 32'h320);
    pulse(3'b010, 3'b100);
    @(negedge lb_clk);
    #2 lb_rst_n = 1'b0;
    #1;
    check("midwait_rst_outputs_zero",
          |{m_wack, m_rack, m_rdata, lb_wreq, lb_waddr, lb_wdata, lb_rreq, lb_raddr, to_err, to_cnt}, 0);
    check("midwait_rst_to_cnt", to_cnt, 0);
    exp_strobes.delete(); exp_acks.delete();
    outstanding = 1'b0; exp_to = 0; mack_cyc = -100;
    strobes_before = n_strobes;
    repeat (2) @(negedge lb_clk);
    lb_rst_n = 1'b1;
    repeat (20) @(negedge lb_clk);
    check("no_strobe_after_reset", n_strobes, strobes_before);

    // Fresh requests after reset: pointer is back at MN-1, so M0 before M1
    slave_delay = 2; slave_rdata = 32'h600D_F00D;
    set_w(1, 32'h500, 32'h5050_5050); set_r(0, 32'h504);
    push_s(0, 32'h504, '0); push_s(1, 32'h500, 32'h5050_5050);
    push_a(0, 0, 32'h600D_F00D, 0); push_a(1, 1, '0, 0);
    pulse(3'b010, 3'b001);
    wait_done("post_reset", 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
